cnn_layer_sequencer: RTL and testbench
======================================

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 SHALL provide parameter NUM_STAGES, default 3, number of sequenced layer engines (conv, pool, fc by default), legal range 1..8.
REQ-002 SHALL provide parameter DATA_W, default 32, width of the final-stage result.
REQ-003 SHALL provide parameter TMO_W, default 16, width of the per-stage timeout limit and timer.
REQ-004 SHALL provide parameter CNT_W, default 32, width of the run cycle counter.
REQ-005 Ports, in order; one clock, reset synchronous active-high:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  level; low freezes the sequencer
start  in  1  run request, sampled in IDLE/DONE/ERROR
abort  in  1  kill the current run
continuous  in  1  auto-restart after DONE
stage_mask  in  NUM_STAGES  stage k runs iff bit k set; sampled at run start
timeout_limit  in  TMO_W  max WAIT cycles per stage; 0 disables timeout
stage_start  out  NUM_STAGES  one-hot single-cycle launch pulse
stage_done  in  NUM_STAGES  per-stage completion
result_in  in  DATA_W  last-stage result, valid with its stage_done
value  out  DATA_W  latched run result
done  out  1  run complete, sticky
busy  out  1  run in progress
error  out  1  run failed, sticky
err_code  out  2  01 timeout, 10 empty mask, 11 abort
err_stage  out  3  stage index at failure
cycle_count  out  CNT_W  cycles of last successful run

Function
REQ-006 FSM states SHALL be IDLE, LAUNCH, WAIT, DONE, ERROR; all outputs registered.
REQ-007 IDLE/DONE/ERROR, enable=1, start=1: latch stage_mask; cur = lowest set bit; go LAUNCH; clear done, error, err_code, cycle timer. Mask zero: go ERROR, err_code=10, err_stage=0.
REQ-008 LAUNCH: stage_start[cur]=1 for exactly this cycle; per-stage timer cleared; next WAIT.
REQ-009 WAIT: only stage_done[cur] is honoured; other stage_done bits ignored.
REQ-010 WAIT, stage_done[cur]=1, higher mask bit set: cur = next higher set bit; go LAUNCH (next launch pulse one cycle after the done cycle).
REQ-011 WAIT, stage_done[cur]=1, no higher set bit: value <= result_in; cycle_count <= run timer + 1; go DONE.
REQ-012 WAIT without done: timer increments; when timeout_limit!=0 and timer reaches timeout_limit-1, go ERROR, err_code=01, err_stage=cur. stage_done on that same cycle SHALL win over timeout.
REQ-013 DONE: done=1, busy=0; if continuous=1 and enable=1 with no start, relaunch with held mask next cycle (done drops on relaunch).
REQ-014 ERROR: error=1 held until new start or rst; value and cycle_count unchanged.
REQ-015 abort=1 in LAUNCH or WAIT SHALL go ERROR, err_code=11, err_stage=cur, suppressing any stage_start that cycle; abort in IDLE/DONE/ERROR ignored. Priority: rst > abort > stage_done > timeout.
REQ-016 enable=0 SHALL hold state, cur, timers and outputs; no stage_start pulse issued; a LAUNCH pulse is deferred to the first enable=1 cycle. abort still acts while enable=0.
REQ-017 busy=1 exactly in LAUNCH and WAIT.
REQ-018 Run timer counts every enabled cycle from first LAUNCH; saturates at all-ones, no wrap.

Reset
REQ-019 rst=1 SHALL force IDLE, cur=0, stage_start=0, value=0, done=0, busy=0, error=0, err_code=0, err_stage=0, cycle_count=0, mid-run included, without pulsing any stage_start.

Verification
REQ-020 mask=111, start at cycle 0, each stage_done 3 cycles after its launch, result_in=0x2A -> stage_start[0],[1],[2] at cycles 1,5,9; done=1 at cycle 13; value=0x2A; cycle_count=12.
REQ-021 mask=101 -> stage 1 never launched; launches at 0 then 2; done after stage 2.
REQ-022 timeout_limit=4, stage 1 never completes -> error=1, err_code=01, err_stage=1 four cycles after its launch; stage 2 never launched.
REQ-023 abort during stage 0 WAIT; separately rst mid-stage 1 -> err_code=11,err_stage=0; after rst all outputs zero, no further stage_start.
REQ-024 enable low for 5 cycles in LAUNCH -> pulse delayed exactly 5 cycles, single-cycle; mask=000 start -> err_code=10.
REQ-025 continuous=1, mask=011 -> back-to-back runs, done one cycle per run, stage_start[0] one cycle after each DONE.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// CNN layer sequencer: launches the masked layer engines in index order,
// guards each stage with a timeout and latches the final-stage result.
module cnn_layer_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int DATA_W     = 32,
  parameter int TMO_W      = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic [TMO_W-1:0]      timeout_limit,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [DATA_W-1:0]     result_in,
  output logic [DATA_W-1:0]     value,
  output logic                  done,
  output logic                  busy,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [2:0]            err_stage,
  output logic [CNT_W-1:0]      cycle_count
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT, DONE, ERROR
  } state_t;

  localparam logic [1:0] E_TMO   = 2'b01;
  localparam logic [1:0] E_EMPTY = 2'b10;
  localparam logic [1:0] E_ABORT = 2'b11;

  function automatic logic [2:0] low_bit(
    input logic [NUM_STAGES-1:0] m
  );
    logic [2:0] r;
    r = '0;
    for (int i = NUM_STAGES-1; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [NUM_STAGES-1:0] onehot(
    input logic [2:0] c
  );
    logic [NUM_STAGES-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      r[i] = (3'(i) == c);
    return r;
  endfunction

  state_t                state_q, state_n;
  logic [2:0]            cur_q, cur_n;
  logic [2:0]            estg_q, estg_n;
  logic [2:0]            hi_idx;
  logic [NUM_STAGES-1:0] mask_q, mask_n;
  logic [NUM_STAGES-1:0] launch_q, launch_n;
  logic [TMO_W-1:0]      stmr_q, stmr_n, stmr_inc;
  logic [CNT_W-1:0]      rtmr_q, rtmr_n, rtmr_inc;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [DATA_W-1:0]     value_q, value_n;
  logic [1:0]            code_q, code_n;
  logic                  done_q, done_n;
  logic                  busy_q, busy_n;
  logic                  error_q, error_n;
  logic                  has_hi, done_cur, tmo_hit;

  // both timers saturate instead of wrapping
  assign rtmr_inc = &rtmr_q ? rtmr_q
                            : rtmr_q + CNT_W'(1);
  assign stmr_inc = &stmr_q ? stmr_q
                            : stmr_q + TMO_W'(1);

  assign tmo_hit = (timeout_limit != '0) &&
    (stmr_q >= timeout_limit - TMO_W'(1));

  always_comb begin
    has_hi   = 1'b0;
    hi_idx   = '0;
    done_cur = 1'b0;
    for (int i = NUM_STAGES-1; i >= 0; i--)
      if (mask_q[i] && (3'(i) > cur_q)) begin
        has_hi = 1'b1;
        hi_idx = 3'(i);
      end
    for (int i = 0; i < NUM_STAGES; i++)
      if (3'(i) == cur_q) done_cur = stage_done[i];
  end

  always_comb begin
    state_n = state_q;
    cur_n   = cur_q;
    mask_n  = mask_q;
    stmr_n  = stmr_q;
    rtmr_n  = rtmr_q;
    cnt_n   = cnt_q;
    value_n = value_q;
    done_n  = done_q;
    error_n = error_q;
    code_n  = code_q;
    estg_n  = estg_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (enable && start) begin
          mask_n  = stage_mask;
          done_n  = 1'b0;
          error_n = 1'b0;
          code_n  = '0;
          estg_n  = '0;
          rtmr_n  = '0;
          stmr_n  = '0;
          if (stage_mask == '0) begin
            state_n = ERROR;
            error_n = 1'b1;
            code_n  = E_EMPTY;
          end else begin
            state_n = LAUNCH;
            cur_n   = low_bit(stage_mask);
          end
        end else if (state_q == DONE &&
                     enable && continuous) begin
          state_n = LAUNCH;
          cur_n   = low_bit(mask_q);
          done_n  = 1'b0;
          rtmr_n  = '0;
          stmr_n  = '0;
        end
      end
      LAUNCH, WAIT: begin
        if (abort) begin
          state_n = ERROR;
          error_n = 1'b1;
          code_n  = E_ABORT;
          estg_n  = cur_q;
        end else if (enable) begin
          rtmr_n = rtmr_inc;
          stmr_n = stmr_inc;
          if (state_q == LAUNCH) begin
            state_n = WAIT;
          end else if (done_cur) begin
            if (has_hi) begin
              state_n = LAUNCH;
              cur_n   = hi_idx;
              stmr_n  = '0;
            end else begin
              state_n = DONE;
              done_n  = 1'b1;
              value_n = result_in;
              cnt_n   = rtmr_inc;
            end
          end else if (tmo_hit) begin
            state_n = ERROR;
            error_n = 1'b1;
            code_n  = E_TMO;
            estg_n  = cur_q;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_n   = (state_n == LAUNCH) ||
                    (state_n == WAIT);
  assign launch_n = (state_n == LAUNCH) ?
                    onehot(cur_n) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      mask_q   <= '0;
      launch_q <= '0;
      stmr_q   <= '0;
      rtmr_q   <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= '0;
      estg_q   <= '0;
    end else begin
      state_q  <= state_n;
      cur_q    <= cur_n;
      mask_q   <= mask_n;
      launch_q <= launch_n;
      stmr_q   <= stmr_n;
      rtmr_q   <= rtmr_n;
      cnt_q    <= cnt_n;
      value_q  <= value_n;
      done_q   <= done_n;
      busy_q   <= busy_n;
      error_q  <= error_n;
      code_q   <= code_n;
      estg_q   <= estg_n;
    end
  end

  // pending launch fires only on a live, un-aborted cycle
  assign stage_start = launch_q &
    {NUM_STAGES{enable & ~abort & ~rst}};

  assign value       = value_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign error       = error_q;
  assign err_code    = code_q;
  assign err_stage   = estg_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: modelled stage engines,
// scoreboard of run outcomes and a log of launch pulses.
module tb_cnn_layer_sequencer;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst, enable, start, abort, continuous;
  logic [N-1:0]  stage_mask, stage_start;
  logic [N-1:0]  stage_done = '0;
  logic [TW-1:0] timeout_limit;
  logic [DW-1:0] result_in, value;
  logic          done, busy, error;
  logic [1:0]    err_code;
  logic [2:0]    err_stage;
  logic [CW-1:0] cycle_count;

  cnn_layer_sequencer #(
    .NUM_STAGES(N), .DATA_W(DW),
    .TMO_W(TW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .start(start), .abort(abort),
    .continuous(continuous),
    .stage_mask(stage_mask),
    .timeout_limit(timeout_limit),
    .stage_start(stage_start),
    .stage_done(stage_done),
    .result_in(result_in), .value(value),
    .done(done), .busy(busy), .error(error),
    .err_code(err_code), .err_stage(err_stage),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] v;
    logic [CW-1:0] c;
    logic          err;
    logic [1:0]    code;
    logic [2:0]    stg;
  } exp_t;
  typedef struct {
    int           c;
    logic [N-1:0] s;
  } lau_t;

  exp_t exp_q[$];
  lau_t lau_q[$];
  int   nerr = 0;
  int   nchk = 0;
  int   t0   = 0;
  logic [DW-1:0] mv = '0;
  logic [CW-1:0] mc = '0;
  logic [N-1:0]  resp_en = '1;
  int   rcnt[N];

  // stage engines answer 3 cycles after their launch pulse
  always @(negedge clk) begin : engines
    logic [N-1:0] d;
    d = '0;
    for (int k = 0; k < N; k++) begin
      if (rst) rcnt[k] = 0;
      else if (stage_start[k]) rcnt[k] = 3;
      else if (rcnt[k] > 0) begin
        rcnt[k]--;
        d[k] = (rcnt[k] == 0) && resp_en[k];
      end
    end
    stage_done = d;
    if (stage_start != '0)
      lau_q.push_back('{cyc, stage_start});
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input logic [N-1:0] m);
    lau_q.delete();
    stage_mask = m;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic push_ok(input logic [DW-1:0] v,
                         input logic [CW-1:0] c);
    exp_q.push_back('{v, c, 1'b0, 2'b00, 3'd0});
    mv = v;
    mc = c;
  endtask

  task automatic push_err(input logic [1:0] code,
                          input logic [2:0] stg);
    exp_q.push_back('{mv, mc, 1'b1, code, stg});
  endtask

  task automatic wait_end(input string tag,
                          input int rel);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cyc"}, cyc - t0, rel);
    chk({tag, "_sb"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_value"}, value, e.v);
      chk({tag, "_count"}, cycle_count, e.c);
      chk({tag, "_error"}, error, e.err);
      chk({tag, "_done"}, done, !e.err);
      chk({tag, "_code"}, err_code, e.code);
      chk({tag, "_estg"}, err_stage, e.stg);
      chk({tag, "_busy"}, busy, 0);
    end
  endtask

  task automatic chk_lau(input string tag,
                         input int rel,
                         input int stg);
    lau_t l;
    chk({tag, "_have"}, lau_q.size() != 0, 1);
    if (lau_q.size() != 0) begin
      l = lau_q.pop_front();
      chk({tag, "_at"}, l.c - t0, rel);
      chk({tag, "_oh"}, l.s, N'(1) << stg);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    stage_mask = '0;
    timeout_limit = '0;
    result_in = '0;
    step(3);
    chk("rst_value", value, 0);
    chk("rst_flags", {done, busy, error}, 0);
    chk("rst_err", {err_code, err_stage}, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_start", stage_start, 0);
    rst = 1'b0;
    enable = 1'b1;
    step(2);

    // full three-stage run
    result_in = 32'h2A;
    push_ok(32'h2A, 12);
    go(3'b111);
    wait_end("run111", 13);
    chk_lau("l111_0", 1, 0);
    chk_lau("l111_1", 5, 1);
    chk_lau("l111_2", 9, 2);
    step(2);
    chk("done_sticky", done, 1);
    chk("value_held", value, 32'h2A);
    chk("l111_extra", lau_q.size(), 0);

    // sparse mask skips stage 1
    step(2);
    result_in = 32'h55;
    push_ok(32'h55, 8);
    go(3'b101);
    wait_end("run101", 9);
    chk_lau("l101_0", 1, 0);
    chk_lau("l101_2", 5, 2);
    chk("l101_extra", lau_q.size(), 0);

    // stage 1 hangs, timeout of 4
    step(4);
    timeout_limit = 16'd4;
    resp_en = 3'b101;
    push_err(2'b01, 3'd1);
    go(3'b111);
    wait_end("tmo", 9);
    step(4);
    chk_lau("ltmo_0", 1, 0);
    chk_lau("ltmo_1", 5, 1);
    chk("ltmo_extra", lau_q.size(), 0);
    timeout_limit = '0;
    resp_en = '1;

    // abort during stage 0 wait
    step(4);
    push_err(2'b11, 3'd0);
    go(3'b111);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_end("abort", 3);
    chk_lau("labt_0", 1, 0);
    step(4);
    chk("labt_extra", lau_q.size(), 0);

    // reset in the middle of stage 1
    go(3'b111);
    step(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mv = '0;
    mc = '0;
    chk("mrst_value", value, mv);
    chk("mrst_count", cycle_count, mc);
    chk("mrst_flags", {done, busy, error}, 0);
    chk("mrst_err", {err_code, err_stage}, 0);
    step(10);
    chk_lau("lrst_0", 1, 0);
    chk_lau("lrst_1", 5, 1);
    chk("lrst_extra", lau_q.size(), 0);

    // launch held off by 5 disabled cycles
    result_in = 32'h77;
    push_ok(32'h77, 4);
    go(3'b001);
    enable = 1'b0;
    step(2);
    chk("dis_busy", busy, 1);
    chk("dis_nopulse", lau_q.size(), 0);
    step(3);
    enable = 1'b1;
    wait_end("dis", 10);
    chk_lau("ldis_0", 6, 0);
    chk("ldis_extra", lau_q.size(), 0);

    // empty mask
    step(4);
    push_err(2'b10, 3'd0);
    go(3'b000);
    wait_end("empty", 1);
    chk("lemp_none", lau_q.size(), 0);

    // continuous back-to-back runs
    step(4);
    result_in = 32'h99;
    continuous = 1'b1;
    push_ok(32'h99, 8);
    push_ok(32'h99, 8);
    go(3'b011);
    wait_end("cont1", 9);
    step();
    chk("cont_drop", done, 0);
    continuous = 1'b0;
    wait_end("cont2", 18);
    step(4);
    chk("cont_stay", done, 1);
    chk_lau("lc_0", 1, 0);
    chk_lau("lc_1", 5, 1);
    chk_lau("lc_2", 10, 0);
    chk_lau("lc_3", 14, 1);
    chk("lc_extra", lau_q.size(), 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
